// File: rtl/range_counter.sv
// Bounded up/down counter between start_val_i and end_val_i with stop, wrap
// and ping-pong modes. All outputs are registered.
module range_counter #(
  parameter int Bits     = 8,
  parameter int StepBits = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                restart_i,
  input  logic [1:0]          mode_i,
  input  logic [StepBits-1:0] step_i,
  input  logic [Bits-1:0]     start_val_i,
  input  logic [Bits-1:0]     end_val_i,
  output logic [Bits-1:0]     count_o,
  output logic                dir_o,
  output logic                done_o,
  output logic                wrap_o
);

  localparam int CmpW = (Bits > StepBits) ? Bits : StepBits;

  typedef enum logic [1:0] {
    ModeStop = 2'b00,
    ModeWrap = 2'b01,
    ModePing = 2'b10,
    ModeRsvd = 2'b11
  } mode_e;

  mode_e           mode;
  logic [CmpW-1:0] step_w;
  logic [CmpW-1:0] up_room;
  logic [CmpW-1:0] dn_room;

  logic [Bits-1:0] count_q, count_d;
  logic            dir_q, dir_d;
  logic            done_q, done_d;
  logic            wrap_q, wrap_d;

  assign mode = mode_e'(mode_i);

  // Bounds are tested as distances so count +/- step never has to be formed
  // before we know it stays inside [start, end].
  always_comb begin
    step_w  = (step_i == '0) ? CmpW'(1) : CmpW'(step_i);
    up_room = CmpW'(end_val_i - count_q);
    dn_room = CmpW'(count_q - start_val_i);
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    if (restart_i) begin
      count_d = start_val_i;
      dir_d   = 1'b0;
      done_d  = 1'b0;
    end else if (en_i) begin
      unique case (mode)
        ModeWrap: begin
          dir_d  = 1'b0;
          done_d = 1'b0;
          if (up_room >= step_w) begin
            count_d = count_q + Bits'(step_w);
          end else begin
            count_d = start_val_i;
            wrap_d  = 1'b1;
          end
        end
        ModePing: begin
          done_d = 1'b0;
          if (!dir_q) begin
            if (up_room > step_w) begin
              count_d = count_q + Bits'(step_w);
            end else begin
              count_d = end_val_i;
              dir_d   = 1'b1;
              wrap_d  = 1'b1;
            end
          end else begin
            if (dn_room > step_w) begin
              count_d = count_q - Bits'(step_w);
            end else begin
              count_d = start_val_i;
              dir_d   = 1'b0;
              wrap_d  = 1'b1;
            end
          end
        end
        default: begin
          dir_d = 1'b0;
          if (up_room > step_w) begin
            count_d = count_q + Bits'(step_w);
            done_d  = 1'b0;
          end else begin
            count_d = end_val_i;
            done_d  = 1'b1;
          end
        end
      endcase
    end
  end

  // Reset loads the live start value, so count_o tracks start_val_i during reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= start_val_i;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign dir_o   = dir_q;
  assign done_o  = done_q;
  assign wrap_o  = wrap_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && (end_val_i < start_val_i))
      $error("range_counter: end_val_i < start_val_i");
  end
`endif

endmodule

// File: doc/range_counter.md
RANGE_COUNTER -- requirements
Module: range_counter

Interface
REQ-001 SHALL have parameter Bits, default 8: counter width in bits.
REQ-002 SHALL have parameter StepBits, default 4: width of the step input.
REQ-003 SHALL have port clk_i  input  1: single clock; all state changes on its rising edge except reset.
REQ-004 SHALL have port rst_i  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port en_i  input  1: advance enable; low holds all state.
REQ-006 SHALL have port restart_i  input  1: synchronous reload to start value.
REQ-007 SHALL have port mode_i  input  2: 00 stop, 01 wrap, 10 ping-pong, 11 treated as stop.
REQ-008 SHALL have port step_i  input  StepBits: increment/decrement amount, unsigned.
REQ-009 SHALL have port start_val_i  input  Bits: lower bound and reload value.
REQ-010 SHALL have port end_val_i  input  Bits: upper bound.
REQ-011 SHALL have port count_o  output  Bits: current count, registered.
REQ-012 SHALL have port dir_o  output  1: current direction, 0 up, 1 down.
REQ-013 SHALL have port done_o  output  1: level, high while stopped at end_val_i in stop mode.
REQ-014 SHALL have port wrap_o  output  1: one-cycle pulse on each wrap or ping-pong turnaround.

Function
REQ-015 SHALL apply priority rst_i > restart_i > en_i.
REQ-016 SHALL, on restart_i high at a clock edge, load count_o=start_val_i, dir_o=0, done_o=0, wrap_o=0, regardless of en_i.
REQ-017 SHALL hold count_o, dir_o and done_o, and drive wrap_o=0, on an edge with en_i low and restart_i low.
REQ-018 SHALL compute all comparisons as distances: up_room = end_val_i - count_o and dn_room = count_o - start_val_i, Bits wide. No Bits-wide overflow is permitted in any comparison.
REQ-019 SHALL treat step_i=0 as step 1.
REQ-020 Stop mode: if up_room > step, count_o += step; otherwise count_o = end_val_i and done_o = 1. Once done, SHALL hold at end_val_i with wrap_o = 0.
REQ-021 Wrap mode: if up_room >= step, count_o += step; otherwise count_o = start_val_i and wrap_o = 1 for that cycle. Residual step is not carried over. done_o stays 0.
REQ-022 Ping-pong up (dir_o=0): if up_room > step, count_o += step; otherwise count_o = end_val_i, dir_o = 1, wrap_o = 1.
REQ-023 Ping-pong down (dir_o=1): if dn_room > step, count_o -= step; otherwise count_o = start_val_i, dir_o = 0, wrap_o = 1.
REQ-024 In stop and wrap modes, SHALL force dir_o to 0 on every enabled edge.
REQ-025 SHALL, when start_val_i == end_val_i, hold count_o at that value in all modes. In stop mode done_o = 1 on the first enabled edge. In wrap and ping-pong modes wrap_o pulses on every enabled edge.
REQ-026 SHALL take effect on the next enabled edge when mode_i changes mid-count. count_o is kept. If the new mode is stop, done_o is re-evaluated by REQ-020.
REQ-027 SHALL treat end_val_i < start_val_i as illegal. Outputs are then unspecified, but the block SHALL not lock up: restart_i still recovers it.
REQ-028 SHALL provide a simulation-only check that flags end_val_i < start_val_i on every clock edge.
REQ-029 SHALL contain no combinational path from any input to count_o, dir_o, done_o or wrap_o.

Reset
REQ-030 SHALL, while rst_i is high, immediately and independently of clk_i, drive count_o=start_val_i, dir_o=0, done_o=0, wrap_o=0.
REQ-031 SHALL resume counting on the first enabled rising edge after rst_i deasserts. Reset released between edges yields start_val_i+step at that edge.

Verification
REQ-032 Stop mode: Bits=8, start 0x00, end 0x0A, step 3, en high -> count 3,6,9,10,10. done_o rises with the first 10 and stays high.
REQ-033 Wrap mode: start 0x10, end 0x14, step 2 -> 0x12,0x14,0x10 (wrap_o pulse),0x12. Second case: end 0xFF, start 0xF0, step 15 -> 0xFF, then 0xF0 with no overflow.
REQ-034 Ping-pong mode: start 5, end 9, step 2 -> 7,9 (dir 1, wrap_o),7,5 (dir 0, wrap_o),7.
REQ-035 Async reset mid-count: assert rst_i between edges with count 0x40 and start 0x20 -> count_o 0x20 before the next edge. After release, first enabled edge gives 0x20+step.
REQ-036 Restart with en_i low while count 0x33 -> next edge count=start, done_o=0. Restart asserted together with en_i -> restart wins.
REQ-037 Enable toggle, stop mode, start 50, end 100, step 1: alternate en_i each cycle -> count advances only on enabled edges and holds otherwise; done_o at 100.
